cache_sa: RTL and testbench
===========================

# cache_sa

Parametrised set-associative, write-through, word-line cache between the core's load/store port and the data RAM. It generalises the direct-mapped cache to `WAYS` ways with round-robin replacement and a req/ack handshake to a multi-cycle memory. It also adds a miss state machine, a bulk flush, and optional hit/miss counters. Read hits complete in the request cycle; misses and all writes stall the core until memory acknowledges.

## Interface
Parameters:
- `DATA_WIDTH`, 32: address and data width.
- `SET_SIZE`, 3: log2 of the number of sets.
- `WAYS`, 2: ways per set; power of two, 1..8. `WAYS`=1 gives a direct-mapped cache.

Ports:
- `clk`  in  1: clock. Rising-edge.
- `rst_i`  in  1: reset. Asynchronous, active-high.
- `req_i`  in  1: core access request.
- `we_i`  in  1: 1 = store, 0 = load. Qualified by `req_i`.
- `addr_i`  in  DATA_WIDTH: byte address. Bits [1:0] are ignored.
- `wdata_i`  in  DATA_WIDTH: store data.
- `flush_i`  in  1: invalidate all lines.
- `rdata_o`  out  DATA_WIDTH: load data. Valid when `ready_o`=1.
- `ready_o`  out  1: access complete this cycle.
- `mem_req_o`  out  1: memory request.
- `mem_we_o`  out  1: memory write.
- `mem_addr_o`  out  DATA_WIDTH: memory address.
- `mem_wdata_o`  out  DATA_WIDTH: memory write data.
- `mem_rdata_i`  in  DATA_WIDTH: memory read data. Valid with `mem_ack_i`.
- `mem_ack_i`  in  1: memory done. Single-cycle pulse.
- `hit_count_o`, `miss_count_o`  out  32: only present with `CACHE_STATS_EN`.

## Operation
Address fields:
- index = `addr_i[SET_SIZE+1:2]`
- tag = `addr_i[DATA_WIDTH-1:SET_SIZE+2]`

Line state:
- Each way stores `valid`, tag and one data word.
- Each set has a round-robin pointer of `log2(WAYS)` bits.

Hit rule:
- Hit = some way of the indexed set has `valid`=1 and a matching tag.
- At most one way can match, because writes update a hit way in place.

Victim selection:
- The lowest-index invalid way, if one exists.
- Otherwise, the way named by the set's pointer. The pointer increments (mod `WAYS`) on every fill.

State machine (IDLE, MEM_RD, MEM_WR, RESP):
- IDLE, `flush_i`=1: clear every `valid` bit and pointer at the next edge. Any same-cycle `req_i` is not accepted (`ready_o`=0).
- IDLE, `req_i` and `!we_i` and hit: `ready_o`=1 and `rdata_o` = way data, combinationally. Stay in IDLE; no state changes.
- IDLE, `req_i` and `!we_i` and miss: latch address and victim, go to MEM_RD.
- IDLE, `req_i` and `we_i`: latch address, data, hit way (or victim), go to MEM_WR.
- MEM_RD: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = latched address. On `mem_ack_i`: write `mem_rdata_i`, tag and `valid` into the victim, latch the data for the response, go to RESP.
- MEM_WR: `mem_req_o`=1, `mem_we_o`=1, `mem_wdata_o` = latched data. On `mem_ack_i`:
  - on a hit, update the hit way's data;
  - on a miss, allocate the victim (write-allocate; the pointer advances);
  - then go to RESP.
- RESP: `ready_o`=1. `rdata_o` = filled data for a load, or the written word for a store. Go to IDLE.

Core-side rules:
- The core holds `req_i`, `we_i`, `addr_i` and `wdata_i` stable until `ready_o`=1.
- The cache uses only its latched copies after leaving IDLE.

Other rules:
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` stay constant until ack.
- `mem_ack_i` outside MEM_RD/MEM_WR is ignored.
- `flush_i` outside IDLE is ignored.
- `rdata_o`=0 whenever `ready_o`=0.
- Unused memory outputs are 0 when `mem_req_o`=0.

## Timing
- Read hit: zero-latency; `ready_o` is high in the request cycle.
- Read miss or write: request accepted at cycle T with `ready_o`=0. `mem_req_o` is high from T+1. Ack arrives at T+1+L (L≥0). `ready_o`=1 at T+2+L. A back-to-back request is accepted at T+3+L.
- Reset values: state IDLE; all `valid` bits and pointers 0; `ready_o`, `rdata_o` and all `mem_*_o` are 0; counters 0.
- Reset mid-miss: `mem_req_o` drops asynchronously and the transaction is abandoned. No line is written. A later ack is ignored.
- The line write and the state transition occur on the ack edge.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count_o` increments on each accepted read hit in IDLE.
  - `miss_count_o` increments on each accepted read miss.
  - Writes are not counted.
  - Both counters saturate at all-ones, reset to 0, and are unaffected by `flush_i`.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Cold read at 0x40 with memory ack after 3 cycles returning 0xDEADBEEF: `mem_req_o` is high for 4 cycles, `ready_o` pulses once with 0xDEADBEEF. A repeat read hits with `ready_o` in the same cycle and no `mem_req_o`.
- `WAYS`=2: reads 0x00, 0x20 and 0x40 all map to set 0 (`SET_SIZE`=3), leaving 0x40 in way 0. A re-read of 0x20 hits; a re-read of 0x00 misses.
- Write 0x12345678 to a cached 0x40: memory sees `mem_we_o`=1 with that data. A following read of 0x40 hits and returns 0x12345678.
- Fill 0x40, pulse `flush_i` in IDLE together with `req_i`: that request gets no `ready_o`. A later read of 0x40 misses and issues `mem_req_o`.
- Assert `rst_i` while in MEM_RD, then deliver ack after release: outputs go to 0 immediately, the ack is ignored, and the next read of the same address misses.
- With `CACHE_STATS_EN`: 3 misses, 5 hits and 2 writes leave `miss_count_o`=3 and `hit_count_o`=5.

Source files
------------

// File: rtl/cache_sa.sv
// cache_sa: set-associative, write-through, one-word-line cache between the core load/store port
// and a multi-cycle data RAM using a req/ack handshake. Replacement fills the lowest invalid way,
// otherwise the way named by a per-set round-robin pointer.
// Optional build macro CACHE_STATS_EN adds saturating read hit/miss counters.
module cache_sa #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SET_SIZE   = 3,
  parameter int unsigned WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef CACHE_STATS_EN
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o,
`endif
  input  logic                  mem_ack_i
);

  localparam int unsigned Sets = 1 << SET_SIZE;
  localparam int unsigned TagW = DATA_WIDTH - SET_SIZE - 2;
  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StMemRd, StMemWr, StResp} state_e;

  state_e                state_q, state_d;
  logic [WAYS-1:0]       valid_q [Sets];
  logic [WAYS-1:0]       valid_d [Sets];
  logic [TagW-1:0]       tag_q   [Sets][WAYS];
  logic [TagW-1:0]       tag_d   [Sets][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [Sets][WAYS];
  logic [DATA_WIDTH-1:0] data_d  [Sets][WAYS];
  logic [WayW-1:0]       ptr_q   [Sets];
  logic [WayW-1:0]       ptr_d   [Sets];

  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WayW-1:0]       way_q, way_d;
  logic                  hit_q, hit_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;

  logic [SET_SIZE-1:0]   idx, lat_idx;
  logic [TagW-1:0]       tag, lat_tag;
  logic                  hit;
  logic [WayW-1:0]       hit_way, victim;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  acc_rd;

  assign idx     = addr_i[SET_SIZE+1:2];
  assign tag     = addr_i[DATA_WIDTH-1:SET_SIZE+2];
  assign lat_idx = addr_q[SET_SIZE+1:2];
  assign lat_tag = addr_q[DATA_WIDTH-1:SET_SIZE+2];
  assign acc_rd  = (state_q == StIdle) && !flush_i && req_i && !we_i;

  // Round-robin pointer step; a single way always points at way 0.
  function automatic logic [WayW-1:0] next_ptr(input logic [WayW-1:0] p);
    if (WAYS == 1) return '0;
    return p + 1'b1;
  endfunction

  // Tag lookup in the indexed set and victim choice (lowest invalid way wins over the pointer).
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    victim   = ptr_q[idx];
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit      = 1'b1;
        hit_way  = WayW'(w);
        hit_data = data_q[idx][w];
      end
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = WayW'(w);
    end
  end

  // Miss/write state machine, line updates and core-side response.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    way_d     = way_q;
    hit_d     = hit_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    ready_o   = 1'b0;
    rdata_o   = '0;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          for (int s = 0; s < int'(Sets); s++) begin
            valid_d[s] = '0;
            ptr_d[s]   = '0;
          end
        end else if (req_i && !we_i && hit) begin
          ready_o = 1'b1;
          rdata_o = hit_data;
        end else if (req_i) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          hit_d     = we_i && hit;
          way_d     = (we_i && hit) ? hit_way : victim;
          mem_req_d = 1'b1;
          mem_we_d  = we_i;
          state_d   = we_i ? StMemWr : StMemRd;
        end
      end
      StMemRd: begin
        if (mem_ack_i) begin
          valid_d[lat_idx][way_q] = 1'b1;
          tag_d[lat_idx][way_q]   = lat_tag;
          data_d[lat_idx][way_q]  = mem_rdata_i;
          ptr_d[lat_idx]          = next_ptr(ptr_q[lat_idx]);
          rdata_d                 = mem_rdata_i;
          mem_req_d               = 1'b0;
          state_d                 = StResp;
        end
      end
      StMemWr: begin
        if (mem_ack_i) begin
          data_d[lat_idx][way_q] = wdata_q;
          // Write miss allocates the victim; a write hit only refreshes the data word.
          if (!hit_q) begin
            valid_d[lat_idx][way_q] = 1'b1;
            tag_d[lat_idx][way_q]   = lat_tag;
            ptr_d[lat_idx]          = next_ptr(ptr_q[lat_idx]);
          end
          rdata_d   = wdata_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        ready_o = 1'b1;
        rdata_o = rdata_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_req_q ? addr_q : '0;
  assign mem_wdata_o = mem_we_q ? wdata_q : '0;

  // State, line arrays and latched transaction registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      way_q     <= '0;
      hit_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      for (int s = 0; s < int'(Sets); s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      way_q     <= way_d;
      hit_q     <= hit_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating counters of accepted reads; writes and flushes leave them alone.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (acc_rd && hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + 32'd1;
    if (acc_rd && !hit && (miss_cnt_q != '1))  miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  logic unused_acc_rd;
  assign unused_acc_rd = acc_rd;
`endif

endmodule

// File: tb/tb_cache_sa.sv
// tb_cache_sa: directed then randomized accesses to cache_sa. Read data is checked against a flat
// memory image; hit/miss is predicted by a per-set FIFO-of-fills residency model.
module tb_cache_sa;
  localparam int DW = 32;
  localparam int SS = 3;
  localparam int W  = 2;
  localparam int SETS = 1 << SS;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i, we_i, flush_i, mem_ack_i;
  logic [DW-1:0] addr_i, wdata_i, mem_rdata_i;
  logic [DW-1:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic          ready_o, mem_req_o, mem_we_o;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count_o, miss_count_o;
`endif

  always #5 clk = ~clk;

  cache_sa #(.DATA_WIDTH(DW), .SET_SIZE(SS), .WAYS(W)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .flush_i     (flush_i),
    .rdata_o     (rdata_o),
    .ready_o     (ready_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
`ifdef CACHE_STATS_EN
    .hit_count_o (hit_count_o),
    .miss_count_o(miss_count_o),
`endif
    .mem_ack_i   (mem_ack_i)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Reference model: memory image, and per set the tags in fill order (slot = fill number mod W).
  logic [31:0] mem_map [logic [31:0]];
  logic [31:0] res_tag [SETS][W];
  int          fills [SETS];
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_map.exists(a)) return mem_map[a];
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'((a >> 2) % SETS);
    int n = (fills[s] < W) ? fills[s] : W;
    for (int i = 0; i < n; i++) if (res_tag[s][i] == (a >> (SS + 2))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int s = int'((a >> 2) % SETS);
    res_tag[s][fills[s] % W] = a >> (SS + 2);
    fills[s]++;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) fills[s] = 0;
  endfunction

  task automatic check1(input string name, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", name, obs, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", name, obs, exp);
    end
  endtask

  // One core access; lat = cycles between first mem_req_o cycle and ack cycle.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input int lat,
                        output bit saw_hit);
    bit exp_hit;
    exp_hit = model_hit(a);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    @(negedge clk);
    saw_hit = ready_o;
    if (!we && exp_hit) begin
      check1("hit_ready", ready_o, 1'b1);
      check32("hit_rdata", rdata_o, mem_val(a));
      check1("hit_no_mem_req", mem_req_o, 1'b0);
      exp_hits++;
    end else begin
      check1("accept_ready", ready_o, 1'b0);
      check32("accept_rdata", rdata_o, 32'h0);
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        check1("mem_req", mem_req_o, 1'b1);
        check1("mem_we", mem_we_o, we);
        check32("mem_addr", mem_addr_o, a);
        check32("mem_wdata", mem_wdata_o, we ? wd : 32'h0);
        check1("wait_ready", ready_o, 1'b0);
        if (k == lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = we ? $urandom : mem_val(a);
        end
      end
      @(posedge clk); #1;
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      if (we) mem_map[a] = wd;
      else    exp_miss++;
      if (!exp_hit) model_fill(a);
      @(negedge clk);
      check1("resp_ready", ready_o, 1'b1);
      check32("resp_rdata", rdata_o, mem_val(a));
      check1("resp_mem_req", mem_req_o, 1'b0);
    end
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  // Flush in IDLE with a simultaneous read request that must not complete.
  task automatic flush_with_req(input logic [31:0] a);
    @(posedge clk); #1;
    flush_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    check1("flush_ready", ready_o, 1'b0);
    check32("flush_rdata", rdata_o, 32'h0);
    check1("flush_mem_req", mem_req_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0; req_i = 1'b0;
    model_clear();
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check32("hit_count", hit_count_o, exp_hits);
    check32("miss_count", miss_count_o, exp_miss);
`endif
  endtask

  initial begin
    bit h;
    logic [31:0] a;
    int r;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
    model_clear();
    mem_map[32'h40] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_ready", ready_o, 1'b0);
    check32("rst_rdata", rdata_o, 32'h0);
    check1("rst_mem_req", mem_req_o, 1'b0);
    check1("rst_mem_we", mem_we_o, 1'b0);
    check32("rst_mem_addr", mem_addr_o, 32'h0);
    check32("rst_mem_wdata", mem_wdata_o, 32'h0);
    check_stats();
    rst_i = 1'b0;

    // Cold read, latency 3 (mem_req_o high for 4 cycles), then a repeat hit.
    access(1'b0, 32'h40, 32'h0, 3, h);  check1("cold_miss", h, 1'b0);
    access(1'b0, 32'h40, 32'h0, 0, h);  check1("repeat_hit", h, 1'b1);

    // Flush with a same-cycle request; the line is gone afterwards.
    flush_with_req(32'h40);
    access(1'b0, 32'h40, 32'h0, 1, h);  check1("post_flush_miss", h, 1'b0);

    // Three tags in set 0 of a 2-way cache.
    flush_with_req(32'h0);
    access(1'b0, 32'h00, 32'h0, 1, h);  check1("set0_a", h, 1'b0);
    access(1'b0, 32'h20, 32'h0, 0, h);  check1("set0_b", h, 1'b0);
    access(1'b0, 32'h40, 32'h0, 2, h);  check1("set0_c", h, 1'b0);
    access(1'b0, 32'h20, 32'h0, 0, h);  check1("reread_20_hit", h, 1'b1);
    access(1'b0, 32'h00, 32'h0, 1, h);  check1("reread_00_miss", h, 1'b0);

    // Write-through to a cached line, then a hit returning the new word.
    access(1'b1, 32'h40, 32'h12345678, 2, h);
    access(1'b0, 32'h40, 32'h0, 0, h);  check1("write_then_hit", h, 1'b1);
    check_stats();

    // Reset in MEM_RD, late ack ignored, same address misses afterwards.
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h84;
    @(negedge clk);
    check1("rm_accept", ready_o, 1'b0);
    @(negedge clk);
    check1("rm_mem_req", mem_req_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check1("rm_async_req", mem_req_o, 1'b0);
    check32("rm_async_addr", mem_addr_o, 32'h0);
    check1("rm_async_ready", ready_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b0; req_i = 1'b0;
    model_clear();
    exp_hits = 0; exp_miss = 0;
    @(negedge clk);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check1("late_ack_ready", ready_o, 1'b0);
    check1("late_ack_req", mem_req_o, 1'b0);
    check_stats();
    access(1'b0, 32'h84, 32'h0, 1, h);  check1("rm_reread_miss", h, 1'b0);

    // Counter scenario: 3 read misses, 5 read hits, 2 writes.
    access(1'b0, 32'h100, 32'h0, 0, h);
    access(1'b0, 32'h104, 32'h0, 1, h);
    access(1'b0, 32'h108, 32'h0, 0, h);
    for (int i = 0; i < 5; i++) access(1'b0, 32'h100 + 32'(4 * (i % 3)), 32'h0, 0, h);
    access(1'b1, 32'h100, 32'hA5A5A5A5, 1, h);
    access(1'b1, 32'h1F0, 32'h5A5A5A5A, 0, h);
    check_stats();

    // Randomized traffic over a small tag pool to mix hits, misses, evictions and flushes.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      a = (32'($urandom_range(0, 3)) << (SS + 2)) | (32'($urandom_range(0, SETS - 1)) << 2);
      if (r < 4) flush_with_req(a);
      else access(r < 34, a, $urandom, int'($urandom_range(0, 3)), h);
    end
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
